multicycle_ctrl: RTL and testbench

//  Multi-cycle RV32 control unit: the driving end of the ALU control/Zero interface.

---
 rtl/ctrl_pkg.sv | 110 +++++++++++
 rtl/alu_op_decoder.sv | 31 +++
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
// ALU op codes, FSM state encoding, opcodes, mux selects and the control-word bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_PASSB = 4'b0010,
        ALU_JALR  = 4'b0011,
        ALU_LUI   = 4'b0100,
        ALU_LBU   = 4'b0101,
        ALU_SB    = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SUB   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_XOR   = 4'b1010,
        ALU_OR    = 4'b1011,
        ALU_AND   = 4'b1100,
        ALU_BEQ   = 4'b1101
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       retire;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        alu_op:     ALU_ADD,
        src_a:      SRC_A_PC,
        src_b:      SRC_B_RS2,
        imm_src:    IMM_I,
        result_src: RES_ALUOUT,
        adr_src:    ADR_PC,
        ir_write:   1'b0,
        pc_write:   1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        retire:     1'b0
    };

    // Execute-stage state chosen from the opcode alone; funct legality is layered on by the caller.
    function automatic state_e decode_state(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_STORE: decode_state = S_MEMADR;
            OPC_OP:              decode_state = S_EXECR;
            OPC_OP_IMM:          decode_state = S_EXECI;
            OPC_BRANCH:          decode_state = S_BRANCH;
            OPC_JAL:             decode_state = S_JAL;
            OPC_JALR:            decode_state = S_JALR;
            OPC_LUI:             decode_state = S_LUI;
            default:             decode_state = S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational funct3/funct7[5] decode to an ALU op for R-type and I-type arithmetic.
// legal=0 flags funct combinations this core does not implement (SLT/SLTU, arithmetic shifts).
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_imm,
    output alu_op_e    alu_op,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct3)
            3'b000: alu_op = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b100: alu_op = ALU_XOR;
            3'b101: begin
                alu_op = ALU_SRL;
                legal  = !funct7b5;
            end
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences FETCH..WRITEBACK and drives ALU op, mux selects, enables.
// Build option MC_ILLEGAL_TRAP_EN: unknown instructions trap and hold with a sticky illegal flag.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_valid,
    input  logic            zero,
    output logic [3:0]      alu_control,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      imm_src,
    output logic [1:0]      result_src,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            reg_write,
    output logic            mem_write,
    output logic            retire,
    output logic            illegal
);

    state_e     state_q, state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    alu_op_e    dec_alu_op;
    logic       dec_legal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

    alu_op_decoder u_alu_op_decoder (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_imm   (opcode == OPC_OP_IMM),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctrl.src_b      = SRC_B_FOUR;
                ctrl.result_src = RES_ALU;
                if (instr_valid) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures the branch/jump target here, so JAL needs the J immediate.
                ctrl.src_a   = SRC_A_OLDPC;
                ctrl.src_b   = SRC_B_IMM;
                ctrl.imm_src = (opcode == OPC_JAL) ? IMM_J : IMM_B;
                state_d      = decode_state(opcode);
                if ((state_d == S_EXECR || state_d == S_EXECI) && !dec_legal)
                    state_d = S_ILLEGAL;
            end
            S_EXECR: begin
                ctrl.src_a  = SRC_A_RS1;
                ctrl.src_b  = SRC_B_RS2;
                ctrl.alu_op = dec_alu_op;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.src_a   = SRC_A_RS1;
                ctrl.src_b   = SRC_B_IMM;
                ctrl.imm_src = IMM_I;
                ctrl.alu_op  = dec_alu_op;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMADR: begin
                ctrl.src_a = SRC_A_RS1;
                ctrl.src_b = SRC_B_IMM;
                if (opcode == OPC_STORE) begin
                    ctrl.imm_src = IMM_S;
                    ctrl.alu_op  = ALU_SB;
                    state_d      = S_MEMWRITE;
                end else begin
                    ctrl.imm_src = IMM_I;
                    ctrl.alu_op  = ALU_ADD;
                    state_d      = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctrl.adr_src = ADR_ALUOUT;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = ADR_ALUOUT;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes BNE from BEQ, inverting the sense of Zero.
                ctrl.src_a      = SRC_A_RS1;
                ctrl.src_b      = SRC_B_RS2;
                ctrl.alu_op     = ALU_BEQ;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero ^ funct3[0];
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_JAL: begin
                ctrl.src_a      = SRC_A_OLDPC;
                ctrl.src_b      = SRC_B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                state_d         = S_ALUWB;
            end
            S_JALR: begin
                ctrl.src_a      = SRC_A_RS1;
                ctrl.src_b      = SRC_B_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_op     = ALU_JALR;
                ctrl.result_src = RES_ALU;
                ctrl.pc_write   = 1'b1;
                state_d         = S_ALUWB;
            end
            S_LUI: begin
                ctrl.src_b   = SRC_B_IMM;
                ctrl.imm_src = IMM_U;
                ctrl.alu_op  = ALU_LUI;
                state_d      = S_ALUWB;
            end
            S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = S_ILLEGAL;
`else
                ctrl.retire = 1'b1;
                state_d     = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_d == S_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Outputs are forced to the all-zero word while reset is held, independent of the clock.
    assign ctrl_out    = rst_n ? ctrl : '0;
    assign alu_control = ctrl_out.alu_op;
    assign alu_src_a   = ctrl_out.src_a;
    assign alu_src_b   = ctrl_out.src_b;
    assign imm_src     = ctrl_out.imm_src;
    assign result_src  = ctrl_out.result_src;
    assign adr_src     = ctrl_out.adr_src;
    assign ir_write    = ctrl_out.ir_write;
    assign pc_write    = ctrl_out.pc_write;
    assign reg_write   = ctrl_out.reg_write;
    assign mem_write   = ctrl_out.mem_write;
    assign retire      = ctrl_out.retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl (default build, MC_ILLEGAL_TRAP_EN undefined).
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        zero;
    logic [3:0]  alu_control;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic        adr_src, ir_write, pc_write, reg_write, mem_write, retire, illegal;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero        (zero),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .result_src  (result_src),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .retire      (retire),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Expected word: {alu4, src_a2, src_b2, imm3, res2, adr1, ir_write, pc_write, reg_write, mem_write, retire, illegal}
    localparam logic [19:0] E_RST     = 20'h0;
    localparam logic [19:0] E_FETCH   = {4'b0000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 6'b110000};
    localparam logic [19:0] E_FWAIT   = {4'b0000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 6'b000000};
    localparam logic [19:0] E_DEC_B   = {4'b0000, 2'b01, 2'b01, 3'b010, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_DEC_J   = {4'b0000, 2'b01, 2'b01, 3'b011, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_ALUWB   = {4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b001010};
    localparam logic [19:0] E_R_ADD   = {4'b0000, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_R_SUB   = {4'b1000, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_R_XOR   = {4'b1010, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_I_SRL   = {4'b1001, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_MA_LD   = {4'b0000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_MA_ST   = {4'b0110, 2'b10, 2'b01, 3'b001, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_MREAD   = {4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 6'b000000};
    localparam logic [19:0] E_MEMWB   = {4'b0000, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 6'b001010};
    localparam logic [19:0] E_MWRITE  = {4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 6'b000110};
    localparam logic [19:0] E_BR_TK   = {4'b1101, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b010010};
    localparam logic [19:0] E_BR_NT   = {4'b1101, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000010};
    localparam logic [19:0] E_JAL     = {4'b0000, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 6'b010000};
    localparam logic [19:0] E_JALR    = {4'b0011, 2'b10, 2'b01, 3'b000, 2'b10, 1'b0, 6'b010000};
    localparam logic [19:0] E_LUI     = {4'b0100, 2'b00, 2'b01, 3'b100, 2'b00, 1'b0, 6'b000000};
    localparam logic [19:0] E_ILL_NOP = {4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 6'b000010};

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;
    localparam logic [31:0] I_SRLI = 32'h0030D093;
    localparam logic [31:0] I_LBU  = 32'h0040C283;
    localparam logic [31:0] I_SB   = 32'h00208023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_BNE  = 32'h00001063;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_JALR = 32'h000100E7;
    localparam logic [31:0] I_LUI  = 32'h000010B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] instr;
        logic        zero;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] actual();
        return {alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                ir_write, pc_write, reg_write, mem_write, retire, illegal};
    endfunction

    task automatic add(input logic r, input logic iv, input logic [31:0] ins,
                       input logic z, input logic [19:0] e);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.instr = ins; v.zero = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // Drive one row just after the rising edge, compare on the following falling edge.
    task automatic run_row(input vec_t v, input string name);
        @(posedge clk);
        #1;
        rst_n       = v.rst_n;
        instr_valid = v.iv;
        instr       = v.instr;
        zero        = v.zero;
        @(negedge clk);
        check(name, actual(), v.exp);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; zero = 1'b0;

        add(0, 0, I_ADD, 0, E_RST);
        // add: 4 cycles
        add(1, 1, I_ADD, 0, E_FETCH);   add(1, 0, I_ADD, 0, E_DEC_B);
        add(1, 0, I_ADD, 0, E_R_ADD);   add(1, 0, I_ADD, 0, E_ALUWB);
        // sub
        add(1, 1, I_SUB, 0, E_FETCH);   add(1, 0, I_SUB, 0, E_DEC_B);
        add(1, 0, I_SUB, 0, E_R_SUB);   add(1, 0, I_SUB, 0, E_ALUWB);
        // srli
        add(1, 1, I_SRLI, 0, E_FETCH);  add(1, 0, I_SRLI, 0, E_DEC_B);
        add(1, 0, I_SRLI, 0, E_I_SRL);  add(1, 0, I_SRLI, 0, E_ALUWB);
        // xor
        add(1, 1, I_XOR, 0, E_FETCH);   add(1, 0, I_XOR, 0, E_DEC_B);
        add(1, 0, I_XOR, 0, E_R_XOR);   add(1, 0, I_XOR, 0, E_ALUWB);
        // lbu: 5 cycles
        add(1, 1, I_LBU, 0, E_FETCH);   add(1, 0, I_LBU, 0, E_DEC_B);
        add(1, 0, I_LBU, 0, E_MA_LD);   add(1, 0, I_LBU, 0, E_MREAD);
        add(1, 0, I_LBU, 0, E_MEMWB);
        // beq zero=1 taken; bne zero=1 not taken; bne zero=0 taken
        add(1, 1, I_BEQ, 1, E_FETCH);   add(1, 0, I_BEQ, 1, E_DEC_B);
        add(1, 0, I_BEQ, 1, E_BR_TK);
        add(1, 1, I_BNE, 1, E_FETCH);   add(1, 0, I_BNE, 1, E_DEC_B);
        add(1, 0, I_BNE, 1, E_BR_NT);
        add(1, 1, I_BNE, 0, E_FETCH);   add(1, 0, I_BNE, 0, E_DEC_B);
        add(1, 0, I_BNE, 0, E_BR_TK);
        // fetch stall for 3 cycles, then lui
        add(1, 0, I_LUI, 0, E_FWAIT);   add(1, 0, I_LUI, 0, E_FWAIT);
        add(1, 0, I_LUI, 0, E_FWAIT);   add(1, 1, I_LUI, 0, E_FETCH);
        add(1, 0, I_LUI, 0, E_DEC_B);   add(1, 0, I_LUI, 0, E_LUI);
        add(1, 0, I_LUI, 0, E_ALUWB);
        // jal / jalr
        add(1, 1, I_JAL, 0, E_FETCH);   add(1, 0, I_JAL, 0, E_DEC_J);
        add(1, 0, I_JAL, 0, E_JAL);     add(1, 0, I_JAL, 0, E_ALUWB);
        add(1, 1, I_JALR, 0, E_FETCH);  add(1, 0, I_JALR, 0, E_DEC_B);
        add(1, 0, I_JALR, 0, E_JALR);   add(1, 0, I_JALR, 0, E_ALUWB);
        // illegal opcode and unsupported funct3 both retire as NOP
        add(1, 1, I_BAD, 0, E_FETCH);   add(1, 0, I_BAD, 0, E_DEC_B);
        add(1, 0, I_BAD, 0, E_ILL_NOP);
        add(1, 1, I_SLT, 0, E_FETCH);   add(1, 0, I_SLT, 0, E_DEC_B);
        add(1, 0, I_SLT, 0, E_ILL_NOP); add(1, 0, I_SLT, 0, E_FWAIT);

        foreach (vecs[i]) run_row(vecs[i], $sformatf("row%0d", i));

        // Async reset in the middle of a store: mem_write must drop before any clock edge.
        run_row('{1'b1, 1'b1, I_SB, 1'b0, E_FETCH},  "sb_fetch");
        run_row('{1'b1, 1'b0, I_SB, 1'b0, E_DEC_B},  "sb_decode");
        run_row('{1'b1, 1'b0, I_SB, 1'b0, E_MA_ST},  "sb_memadr");
        run_row('{1'b1, 1'b0, I_SB, 1'b0, E_MWRITE}, "sb_memwrite");
        #1 rst_n = 1'b0;
        #1 check("async_rst_outputs", actual(), E_RST);
        check("async_rst_mem_write", {19'h0, mem_write}, 20'h0);
        @(negedge clk);
        check("rst_held", actual(), E_RST);
        run_row('{1'b1, 1'b1, I_ADD, 1'b0, E_FETCH}, "post_rst_fetch");
        run_row('{1'b1, 1'b0, I_ADD, 1'b0, E_DEC_B}, "post_rst_decode");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
